// File: rtl/game_pkg.sv
// Shared constants, state encoding and helpers for the game controller.
package game_pkg;

  localparam int unsigned NUM_PLAYERS = 4;
  localparam int unsigned RUN_SECS_W  = 10;
  localparam int unsigned SCORE_W     = 16;
  localparam int unsigned PCNT_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_RUN       = 2'd2,
    ST_OVER      = 2'd3
  } game_state_e;

  typedef logic [NUM_PLAYERS-1:0] player_mask_t;

  // Number of set bits in a player mask.
  function automatic logic [PCNT_W-1:0] popcount(input player_mask_t m);
    logic [PCNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
      n = n + PCNT_W'(m[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/game_if.sv
// Game controller bus: tick/start/roster/dead stimulus and game status outputs.
// The score field exists only when GAME_CTRL_SCORE_EN is defined.
interface game_if;
  import game_pkg::*;

  logic                            tick;
  logic                            start;
  player_mask_t                    p_en;
  player_mask_t                    dead;
  player_mask_t                    play;
  logic                            enable_board;
  logic [1:0]                      state;
  player_mask_t                    winner;
  logic                            game_over;
  logic [RUN_SECS_W-1:0]           run_secs;
`ifdef GAME_CTRL_SCORE_EN
  logic [NUM_PLAYERS*SCORE_W-1:0]  score;

  modport master (
    output tick, start, p_en, dead,
    input  play, enable_board, state, winner, game_over, run_secs, score
  );
  modport slave (
    input  tick, start, p_en, dead,
    output play, enable_board, state, winner, game_over, run_secs, score
  );
`else
  modport master (
    output tick, start, p_en, dead,
    input  play, enable_board, state, winner, game_over, run_secs
  );
  modport slave (
    input  tick, start, p_en, dead,
    output play, enable_board, state, winner, game_over, run_secs
  );
`endif

endinterface

// File: rtl/tick_timer.sv
// Loadable countdown counter with zero flag, plus the tick-to-seconds prescaler.
module tick_timer #(
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned TICKS_PER_SEC = 60
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero,
  input  logic             sub_clr,
  input  logic             sub_step,
  output logic             sub_wrap
);
  localparam int unsigned SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] cnt;
  logic [SUB_W-1:0] sub;

  assign zero     = (cnt == '0);
  assign sub_wrap = sub_step && (sub == SUB_MAX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || sub_clr) begin
      sub <= '0;
    end else if (sub_step) begin
      sub <= sub_wrap ? '0 : sub + SUB_W'(1);
    end
  end

endmodule

// File: rtl/game_controller.sv
// Game flow controller: IDLE -> COUNTDOWN -> RUN -> OVER with roster lock and winner pick.
// Define GAME_CTRL_SCORE_EN to add per-player tick scores on bus.score.
module game_controller
  import game_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 60,
  parameter int unsigned COUNTDOWN_SEC = 3
) (
  input  logic  clk,
  input  logic  reset,
  game_if.slave bus
);
  localparam int unsigned CD_TICKS = COUNTDOWN_SEC * TICKS_PER_SEC;
  localparam int unsigned CNT_W    = (CD_TICKS > 1) ? $clog2(CD_TICKS) : 1;
  localparam logic [CNT_W-1:0] CD_LOAD = CNT_W'(CD_TICKS - 1);

  game_state_e           state_q, state_d;
  player_mask_t          roster_q, roster_d, play_q, play_d, winner_q, winner_d;
  player_mask_t          alive;
  logic                  enable_q, enable_d, over_q, over_d;
  logic [RUN_SECS_W-1:0] secs_q, secs_d;
  logic [PCNT_W-1:0]     alive_cnt;
  logic                  multi, cd_load, cd_dec, cd_zero, sub_clr, sub_step, sub_wrap;

  assign alive     = roster_q & ~bus.dead;
  assign alive_cnt = popcount(alive);
  assign multi     = (popcount(roster_q) >= PCNT_W'(2));

  assign cd_load  = (state_q == ST_IDLE) && bus.start && (bus.p_en != '0);
  assign cd_dec   = (state_q == ST_COUNTDOWN) && bus.tick && !cd_zero;
  assign sub_clr  = (state_q == ST_COUNTDOWN) && bus.tick && cd_zero;
  assign sub_step = (state_q == ST_RUN) && bus.tick;

  tick_timer #(
    .CNT_W         (CNT_W),
    .TICKS_PER_SEC (TICKS_PER_SEC)
  ) u_tick_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (cd_load),
    .load_val (CD_LOAD),
    .dec      (cd_dec),
    .zero     (cd_zero),
    .sub_clr  (sub_clr),
    .sub_step (sub_step),
    .sub_wrap (sub_wrap)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      roster_q <= '0;
      play_q   <= '0;
      winner_q <= '0;
      enable_q <= 1'b0;
      over_q   <= 1'b0;
      secs_q   <= '0;
    end else begin
      state_q  <= state_d;
      roster_q <= roster_d;
      play_q   <= play_d;
      winner_q <= winner_d;
      enable_q <= enable_d;
      over_q   <= over_d;
      secs_q   <= secs_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    roster_d = roster_q;
    play_d   = play_q;
    winner_d = winner_q;
    enable_d = enable_q;
    over_d   = over_q;
    secs_d   = secs_q;
    case (state_q)
      ST_IDLE: begin
        if (cd_load) begin
          state_d  = ST_COUNTDOWN;
          roster_d = bus.p_en;
          play_d   = bus.p_en;
        end
      end
      ST_COUNTDOWN: begin
        if (sub_clr) begin
          state_d  = ST_RUN;
          enable_d = 1'b1;
          secs_d   = '0;
        end
      end
      ST_RUN: begin
        if (sub_wrap && (secs_q != '1)) begin
          secs_d = secs_q + RUN_SECS_W'(1);
        end
        // Single-player games run until that player dies; others stop at one survivor.
        if (multi ? (alive_cnt <= PCNT_W'(1)) : (alive == '0)) begin
          state_d  = ST_OVER;
          enable_d = 1'b0;
          over_d   = 1'b1;
          winner_d = (multi && (alive_cnt == PCNT_W'(1))) ? alive : '0;
        end
      end
      ST_OVER: begin
        if (bus.start) begin
          state_d  = ST_IDLE;
          roster_d = '0;
          play_d   = '0;
          winner_d = '0;
          over_d   = 1'b0;
          secs_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.state        = state_q;
  assign bus.play         = play_q;
  assign bus.enable_board = enable_q;
  assign bus.winner       = winner_q;
  assign bus.game_over    = over_q;
  assign bus.run_secs     = secs_q;

`ifdef GAME_CTRL_SCORE_EN
  logic [NUM_PLAYERS*SCORE_W-1:0] score_q;

  // Scores reset when a new game is armed and count RUN ticks while alive.
  always_ff @(posedge clk) begin
    if (!reset) begin
      score_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
        if (cd_load) begin
          score_q[i*SCORE_W +: SCORE_W] <= '0;
        end else if (sub_step && alive[i] && (score_q[i*SCORE_W +: SCORE_W] != '1)) begin
          score_q[i*SCORE_W +: SCORE_W] <= score_q[i*SCORE_W +: SCORE_W] + SCORE_W'(1);
        end
      end
    end
  end

  assign bus.score = score_q;
`endif

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: vector table, directed game sequences and a random run vs a model.
module tb_game_controller;
  import game_pkg::*;

  localparam int TPS      = 60;
  localparam int CD_SEC   = 3;
  localparam int CD_TOTAL = TPS * CD_SEC;

  logic clk = 1'b0;
  logic rst;

  game_if bus();

  game_controller #(
    .TICKS_PER_SEC (TPS),
    .COUNTDOWN_SEC (CD_SEC)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: counts ticks and applies the game rules directly.
  int         m_state;
  int         m_cd_ticks;
  int         m_run_ticks;
  logic [3:0] m_roster;
  logic [3:0] m_winner;
  int         m_score[4];

  task automatic model_step(input logic r, input logic tk, input logic st,
                            input logic [3:0] pe, input logic [3:0] dd);
    logic [3:0] alive;
    int         n;
    bit         multi;
    if (!r) begin
      m_state = 0; m_roster = 4'h0; m_winner = 4'h0; m_cd_ticks = 0; m_run_ticks = 0;
      for (int i = 0; i < 4; i++) m_score[i] = 0;
    end else begin
      case (m_state)
        0: if (st && pe != 4'h0) begin
             m_roster = pe; m_state = 1; m_cd_ticks = 0;
             for (int i = 0; i < 4; i++) m_score[i] = 0;
           end
        1: if (tk) begin
             m_cd_ticks++;
             if (m_cd_ticks == CD_TOTAL) begin m_state = 2; m_run_ticks = 0; end
           end
        2: begin
             alive = m_roster & ~dd;
             n     = $countones(alive);
             multi = ($countones(m_roster) >= 2);
             if (tk) begin
               m_run_ticks++;
               for (int i = 0; i < 4; i++)
                 if (alive[i] && m_score[i] < 65535) m_score[i]++;
             end
             if (multi ? (n <= 1) : (n == 0)) begin
               m_state  = 3;
               m_winner = (multi && n == 1) ? alive : 4'h0;
             end
           end
        default: if (st) begin
             m_state = 0; m_roster = 4'h0; m_winner = 4'h0; m_run_ticks = 0;
           end
      endcase
    end
  endtask

  task automatic step(input logic r, input logic tk, input logic st,
                      input logic [3:0] pe, input logic [3:0] dd);
    rst = r; bus.tick = tk; bus.start = st; bus.p_en = pe; bus.dead = dd;
    model_step(r, tk, st, pe, dd);
    @(posedge clk);
    #1;
    rst = 1'b1; bus.tick = 1'b0; bus.start = 1'b0;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int s, input int p, input int en,
                         input int w, input int ov, input int secs);
    chk({nm, " state"}, int'(bus.state), s);
    chk({nm, " play"}, int'(bus.play), p);
    chk({nm, " enable_board"}, int'(bus.enable_board), en);
    chk({nm, " winner"}, int'(bus.winner), w);
    chk({nm, " game_over"}, int'(bus.game_over), ov);
    chk({nm, " run_secs"}, int'(bus.run_secs), secs);
  endtask

  task automatic chk_model(input string nm);
    int secs;
    secs = m_run_ticks / TPS;
    if (secs > 1023) secs = 1023;
    chk_all(nm, m_state, (m_state == 0) ? 0 : int'(m_roster), (m_state == 2) ? 1 : 0,
            int'(m_winner), (m_state == 3) ? 1 : 0, secs);
`ifdef GAME_CTRL_SCORE_EN
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s score%0d", nm, i), int'(bus.score[16*i +: 16]), m_score[i]);
`endif
  endtask

  task automatic go_run(input logic [3:0] pe);
    step(1'b1, 1'b0, 1'b1, pe, 4'h0);
    repeat (CD_TOTAL) step(1'b1, 1'b1, 1'b0, pe, 4'h0);
  endtask

  typedef struct {
    logic       r, tk, st;
    logic [3:0] pe, dd;
    int         rep;
    int         e_state;
    logic [3:0] e_play;
    logic       e_en;
    logic [3:0] e_win;
    logic       e_over;
    int         e_secs;
  } vec_t;

  vec_t vecs [10];

  initial begin
    rst = 1'b1; bus.tick = 1'b0; bus.start = 1'b0; bus.p_en = 4'h0; bus.dead = 4'h0;

    //         r     tk    st    p_en   dead  rep  st  play  en    win   ovr  secs
    vecs[0] = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1,   0, 4'h0, 1'b0, 4'h0, 1'b0, 0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 1,   0, 4'h0, 1'b0, 4'h0, 1'b0, 0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 4'hC, 4'h0, 1,   1, 4'hC, 1'b0, 4'h0, 1'b0, 0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 4'h3, 4'hF, 1,   1, 4'hC, 1'b0, 4'h0, 1'b0, 0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 4'hC, 4'h0, 179, 1, 4'hC, 1'b0, 4'h0, 1'b0, 0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 4'hC, 4'h0, 1,   2, 4'hC, 1'b1, 4'h0, 1'b0, 0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 4'hC, 4'h3, 1,   2, 4'hC, 1'b1, 4'h0, 1'b0, 0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 4'hC, 4'h4, 1,   3, 4'hC, 1'b0, 4'h8, 1'b1, 0};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 4'hC, 4'h0, 1,   0, 4'h0, 1'b0, 4'h0, 1'b0, 0};
    vecs[9] = '{1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 1,   0, 4'h0, 1'b0, 4'h0, 1'b0, 0};

    for (int v = 0; v < 10; v++) begin
      repeat (vecs[v].rep) step(vecs[v].r, vecs[v].tk, vecs[v].st, vecs[v].pe, vecs[v].dd);
      chk_all($sformatf("vec%0d", v), vecs[v].e_state, int'(vecs[v].e_play), int'(vecs[v].e_en),
              int'(vecs[v].e_win), int'(vecs[v].e_over), vecs[v].e_secs);
    end

    // Countdown lasts exactly COUNTDOWN_SEC*TICKS_PER_SEC ticks.
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    step(1'b1, 1'b0, 1'b1, 4'h5, 4'h0);
    chk("cd start state", int'(bus.state), 1);
    repeat (CD_TOTAL - 1) step(1'b1, 1'b1, 1'b0, 4'h5, 4'h0);
    chk("cd last state", int'(bus.state), 1);
    step(1'b1, 1'b1, 1'b0, 4'h5, 4'h0);
    chk_all("cd done", 2, 5, 1, 0, 0, 0);

    // Three players, deaths one after another leave player 3.
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    go_run(4'h7);
    step(1'b1, 1'b0, 1'b0, 4'h0, 4'h1);
    chk("first death state", int'(bus.state), 2);
    step(1'b1, 1'b0, 1'b0, 4'h0, 4'h3);
    chk_all("second death", 3, 7, 0, 4, 1, 0);
    step(1'b1, 1'b0, 1'b0, 4'h0, 4'hF);
    chk("winner held", int'(bus.winner), 4);

    // Simultaneous deaths draw; foreign dead bits are ignored first.
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    go_run(4'hC);
    step(1'b1, 1'b0, 1'b0, 4'h0, 4'h3);
    chk("foreign dead state", int'(bus.state), 2);
    step(1'b1, 1'b0, 1'b0, 4'h0, 4'hC);
    chk_all("draw", 3, 12, 0, 0, 1, 0);

    // Single player, seconds prescaler and score.
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    go_run(4'h1);
    repeat (599) step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
    chk("secs at 599", int'(bus.run_secs), 9);
    step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
    chk("secs at 600", int'(bus.run_secs), 10);
    step(1'b1, 1'b0, 1'b0, 4'h0, 4'h1);
    chk_all("solo over", 3, 1, 0, 0, 1, 10);
`ifdef GAME_CTRL_SCORE_EN
    chk("solo score", int'(bus.score[15:0]), 600);
`endif

    // Reset in the middle of RUN, then an empty-roster start.
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    go_run(4'h3);
    repeat (70) step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
    step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    chk_all("mid reset", 0, 0, 0, 0, 0, 0);
    step(1'b1, 1'b0, 1'b1, 4'h0, 4'h0);
    chk("empty start", int'(bus.state), 0);

    // Roster is locked once the game is armed.
    go_run(4'h5);
    step(1'b1, 1'b0, 1'b0, 4'hA, 4'h0);
    step(1'b1, 1'b1, 1'b0, 4'hF, 4'h0);
    step(1'b1, 1'b0, 1'b1, 4'hF, 4'h0);
    chk("locked play", int'(bus.play), 5);
    chk("locked state", int'(bus.state), 2);

    // Saturation of run_secs and score.
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    go_run(4'h2);
    for (int i = 1; i <= 65600; i++) begin
      step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
      if (i == 61379) chk("secs before sat", int'(bus.run_secs), 1022);
      if (i == 61380) chk("secs at sat", int'(bus.run_secs), 1023);
`ifdef GAME_CTRL_SCORE_EN
      if (i == 65535) chk("score at max", int'(bus.score[31:16]), 65535);
`endif
    end
    chk("secs saturated", int'(bus.run_secs), 1023);
`ifdef GAME_CTRL_SCORE_EN
    chk("score saturated", int'(bus.score[31:16]), 65535);
    chk("score idle player", int'(bus.score[15:0]), 0);
`endif

    // Random traffic against the reference model.
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    chk_model("rnd reset");
    for (int c = 0; c < 4000; c++) begin
      logic       r, tk, st;
      logic [3:0] pe, dd;
      r  = ($urandom_range(0, 699) != 0);
      tk = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 15) == 0);
      pe = 4'($urandom);
      dd = ($urandom_range(0, 40) == 0) ? 4'($urandom) : 4'h0;
      step(r, tk, st, pe, dd);
      chk_model("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter TICKS_PER_SEC, default 60, number of tick pulses per second.
REQ-002 Parameter COUNTDOWN_SEC, default 3, pre-game countdown length in seconds, range 1..15.
REQ-003 clk  input  1  system clock; one clock domain only.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 tick  input  1  one-clk-wide 60 Hz game-step enable pulse, synchronous to clk.
REQ-006 start  input  1  debounced start button, one clk wide per press.
REQ-007 p_en  input  4  player enable switches, bit i = player i+1.
REQ-008 dead  input  4  per-player out-of-game flags.
REQ-009 play  output  4  players in play; drives the per-player dead, gravity and move logic.
REQ-010 enable_board  output  1  ground lines scroll while high.
REQ-011 state  output  2  IDLE=0, COUNTDOWN=1, RUN=2, OVER=3.
REQ-012 winner  output  4  one-hot surviving player at game end; 0 = draw or no winner.
REQ-013 game_over  output  1  high in OVER.
REQ-014 run_secs  output  10  whole seconds elapsed in RUN, saturating.

Function
REQ-015 All outputs SHALL be registered; no combinational path from input to output.
REQ-016 IDLE: play=0, enable_board=0; a start pulse with p_en!=0 latches roster<=p_en, loads cnt<=COUNTDOWN_SEC*TICKS_PER_SEC-1, and enters COUNTDOWN next cycle.
REQ-017 IDLE: a start pulse with p_en==0 SHALL be ignored.
REQ-018 p_en changes outside IDLE SHALL have no effect, because roster is locked.
REQ-019 COUNTDOWN: play=roster, enable_board=0; cnt decrements on each tick; a tick with cnt==0 enters RUN, clears run_secs and clears the sub-second counter.
REQ-020 RUN: play=roster, enable_board=1; alive=roster & ~dead, evaluated every clk, not only on tick.
REQ-021 RUN exit, multi-player roster (popcount>=2): enter OVER on the first cycle popcount(alive)<=1.
REQ-022 RUN exit, single-player roster: enter OVER on the first cycle alive==0.
REQ-023 On RUN->OVER: winner<=alive when popcount(alive)==1 in a multi-player roster; winner<=0 otherwise, including simultaneous deaths and the single-player case.
REQ-024 dead bits outside roster SHALL be ignored; dead SHALL be ignored outside RUN.
REQ-025 run_secs increments when the sub-second tick counter wraps at TICKS_PER_SEC-1, and saturates at 1023.
REQ-026 OVER: enable_board=0, play=roster held, winner and run_secs held, game_over=1.
REQ-027 OVER: a start pulse enters IDLE and clears winner, run_secs and roster.
REQ-028 start in COUNTDOWN or RUN SHALL be ignored.
REQ-029 tick and start coinciding SHALL each be handled per the current state.

Reset
REQ-030 reset low at a clk edge SHALL force state=IDLE, play=0, enable_board=0, winner=0, game_over=0, run_secs=0, roster=0, cnt=0 and all scores=0; this holds mid-game as well.
REQ-031 No asynchronous reset paths.

Configuration
REQ-032 Macro GAME_CTRL_SCORE_EN defined: add output score (64 bits, 16 bits per player, player i at [16i+15:16i]).
REQ-033 With the macro, score[i] increments on each RUN tick while alive[i], saturates at 0xFFFF, is held in OVER, and is cleared on entry to COUNTDOWN.
REQ-034 Macro undefined: no score port and no score logic.

Structure
REQ-035 Shared package game_pkg SHALL hold the NUM_PLAYERS=4 constant, the state encoding, and RUN_SECS_W=10 and SCORE_W=16.
REQ-036 One sub-module, tick_timer, SHALL provide the loadable down-counter with zero flag and the seconds prescaler, instantiated once.

Verification
REQ-037 p_en=0101, start, 180 ticks -> state 1 for exactly 180 ticks, then state 2, enable_board=1, play=0101.
REQ-038 RUN with roster 0111; dead 0001 then 0010 -> OVER on the cycle dead=0011, winner=0100, enable_board=0.
REQ-039 Roster 1100; dead=1100 in the same cycle -> OVER, winner=0000.
REQ-040 Roster 0001; 600 ticks, then dead=0001 -> run_secs=10, winner=0000, OVER; with GAME_CTRL_SCORE_EN, score[15:0]=600.
REQ-041 reset low mid-RUN -> next cycle state=0, play=0, run_secs=0; start with p_en=0000 -> stays IDLE.
REQ-042 Toggle p_en during RUN, then press start -> play unchanged and state stays 2.
